// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - forwarding encodings, scoreboard entry type and source-select helper
package hazard_pkg;

   localparam int REG_ADDR_W = 3;

   localparam logic [1:0] FWD_REGFILE = 2'b00;
   localparam logic [1:0] FWD_MEM     = 2'b01;
   localparam logic [1:0] FWD_WB      = 2'b10;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] dest;
      logic                  is_load;
   } sb_entry_t;

   // A load sitting in EX is never a forwarding source; that case is a load-use stall instead.
   function automatic logic [1:0] fwd_select(input logic uses,
                                             input logic [REG_ADDR_W-1:0] src,
                                             input sb_entry_t ex,
                                             input sb_entry_t mem);
      if (!uses)
         return FWD_REGFILE;
      if (ex.valid && !ex.is_load && ex.dest == src)
         return FWD_MEM;
      if (mem.valid && mem.dest == src)
         return FWD_WB;
      return FWD_REGFILE;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// rtl/hazard_scoreboard_entry.sv - one scoreboard stage register with bubble insert
module hazard_scoreboard_entry
   import hazard_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      bubble,
   input  sb_entry_t d,
   output sb_entry_t q
);

   always_ff @(posedge clk) begin
      if (rst || bubble)
         q <= '0;
      else
         q <= d;
   end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use stall, branch flush and registered EX forwarding selects
module hazard_unit
   import hazard_pkg::*;
#(
   parameter int CNT_W = 16
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] r1Address,
   input  logic [REG_ADDR_W-1:0] r2Address,
   input  logic                  idUsesR1,
   input  logic                  idUsesR2,
   input  logic [REG_ADDR_W-1:0] idDest,
   input  logic                  idRegWrite,
   input  logic                  idLDM,
   input  logic                  branchTaken,
   output logic                  sstall,
   output logic                  flush,
   output logic [1:0]            fwdASel,
   output logic [1:0]            fwdBSel,
   output logic [CNT_W-1:0]      stallCount,
   output logic [CNT_W-1:0]      flushCount
);

   sb_entry_t id_entry;
   sb_entry_t ex_q;
   sb_entry_t mem_q;
   sb_entry_t wb_unused;
   logic      load_use;
   logic      bubble;

   always_comb begin
      id_entry         = '0;
      id_entry.valid   = idRegWrite;
      id_entry.dest    = idDest;
      id_entry.is_load = idLDM;
   end

   always_comb begin
      load_use = ex_q.valid && ex_q.is_load &&
                 ((idUsesR1 && ex_q.dest == r1Address) ||
                  (idUsesR2 && ex_q.dest == r2Address));
      // A taken branch squashes the dependent instruction, so no stall is needed.
      flush  = branchTaken;
      sstall = load_use && !branchTaken;
      bubble = sstall || flush;
   end

   hazard_scoreboard_entry u_ex  (.clk(clk), .rst(rst), .bubble(bubble), .d(id_entry), .q(ex_q));
   hazard_scoreboard_entry u_mem (.clk(clk), .rst(rst), .bubble(1'b0),   .d(ex_q),     .q(mem_q));
   hazard_scoreboard_entry u_wb  (.clk(clk), .rst(rst), .bubble(1'b0),   .d(mem_q),    .q(wb_unused));

   always_ff @(posedge clk) begin
      if (rst || bubble) begin
         fwdASel <= FWD_REGFILE;
         fwdBSel <= FWD_REGFILE;
      end else begin
         fwdASel <= fwd_select(idUsesR1, r1Address, ex_q, mem_q);
         fwdBSel <= fwd_select(idUsesR2, r2Address, ex_q, mem_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stallCount <= '0;
         flushCount <= '0;
      end else begin
         if (sstall && stallCount != {CNT_W{1'b1}})
            stallCount <= stallCount + CNT_W'(1);
         if (flush && flushCount != {CNT_W{1'b1}})
            flushCount <= flushCount + CNT_W'(1);
      end
   end

endmodule
